// File: rtl/systolic_gemm_ctrl.sv
// Output-stationary fp32 systolic GEMM engine with its own feed/flush/drain sequencer.
// Z[ROWS][COLS] = sum over k of A[:,k] * B[k,:], streamed one k-slice per beat.
//
// state   | meaning
// IDLE    | waiting for the first slice of a job
// FEED    | accepting slices; an empty beat becomes a zero bubble
// FLUSH   | ROWS+COLS-1 zero bubbles so the skewed wavefront clears the array
// DRAIN   | presenting accumulator rows one at a time
module systolic_gemm_ctrl #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 32,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_relu,
    input  logic               cfg_accum,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [ROWS*DW-1:0] in_a,
    input  logic [COLS*DW-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RW-1:0]      out_row,
    output logic               out_last,
    output logic [COLS*DW-1:0] out_z,
    output logic [COLS-1:0]    out_d,
    output logic               busy
);

    if (DW != 32) begin : g_dw_chk
        $error("systolic_gemm_ctrl: DW must be 32 (IEEE-754 single)");
    end

    localparam int CW = $clog2(ROWS + COLS);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(ROWS + COLS - 2);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t state, state_nx;
    logic [CW-1:0] flush_cnt;
    logic relu_q;
    logic accept, first_beat, acc_clr, acc_en, out_hs, row_load;
    logic [RW-1:0] row_sel;

    logic [DW-1:0] beat_a [ROWS];
    logic [DW-1:0] beat_b [COLS];
    logic [DW-1:0] a_skew [ROWS];
    logic [DW-1:0] b_skew [COLS];
    logic [DW-1:0] a_dly  [ROWS][ROWS];
    logic [DW-1:0] b_dly  [COLS][COLS];
    logic [DW-1:0] a_reg  [ROWS][COLS];
    logic [DW-1:0] b_reg  [ROWS][COLS];
    logic [DW-1:0] acc    [ROWS][COLS];

    logic [COLS*DW-1:0] row_z, row_relu;
    logic [COLS-1:0]    row_d;

    // Normal numbers only: subnormal inputs/results flush to zero, NaN is treated as infinity.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic        sgn;
        logic [47:0] prod;
        logic [22:0] man;
        logic        grd, stk;
        int          e;
        sgn = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sgn, 31'd0};
        if (x[30:23] == 8'hff || y[30:23] == 8'hff) return {sgn, 8'hff, 23'd0};
        prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (prod[47]) begin
            man = prod[46:24]; grd = prod[23]; stk = |prod[22:0]; e++;
        end else begin
            man = prod[45:23]; grd = prod[22]; stk = |prod[21:0];
        end
        if (grd && (stk || man[0])) begin
            if (&man) begin man = '0; e++; end
            else man = man + 23'd1;
        end
        if (e >= 255) return {sgn, 8'hff, 23'd0};
        if (e <= 0) return {sgn, 31'd0};
        return {sgn, e[7:0], man};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q;
        logic [26:0] mp, mq, msk, dif;
        logic [27:0] sum;
        logic [22:0] man;
        logic        grd, stk;
        int          e, d;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:23] == 8'hff) return x;
        if (y[30:23] == 8'hff) return y;
        if (x[30:0] < y[30:0]) begin p = y; q = x; end
        else begin p = x; q = y; end
        e  = int'(p[30:23]);
        d  = e - int'(q[30:23]);
        mp = {1'b1, p[22:0], 3'b000};
        mq = {1'b1, q[22:0], 3'b000};
        if (d >= 27) begin
            mq = 27'd1;
        end else if (d > 0) begin
            msk   = (27'd1 << d) - 27'd1;
            stk   = |(mq & msk);
            mq    = mq >> d;
            mq[0] = mq[0] | stk;
        end
        if (p[31] == q[31]) begin
            sum = {1'b0, mp} + {1'b0, mq};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e++;
            end
        end else begin
            dif = mp - mq;
            if (dif == '0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!dif[26]) begin dif = dif << 1; e--; end
            end
            sum = {1'b0, dif};
        end
        man = sum[25:3]; grd = sum[2]; stk = sum[1] | sum[0];
        if (grd && (stk || man[0])) begin
            if (&man) begin man = '0; e++; end
            else man = man + 23'd1;
        end
        if (e >= 255) return {p[31], 8'hff, 23'd0};
        if (e <= 0) return {p[31], 31'd0};
        return {p[31], e[7:0], man};
    endfunction

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = reset;
                if (in_valid) state_nx = in_last ? S_FLUSH : S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == '0) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept     = in_valid & in_ready;
    assign first_beat = accept & (state == S_IDLE);
    assign acc_clr    = first_beat & ~cfg_accum;
    assign acc_en     = (state == S_FEED) || (state == S_FLUSH);
    assign out_hs     = out_valid & out_ready;
    assign out_last   = (out_row == RW'(ROWS - 1));
    assign busy       = (state != S_IDLE);
    assign row_load   = (state == S_DRAIN) && (!out_valid || (out_hs && !out_last));
    assign row_sel    = out_valid ? out_row + 1'b1 : '0;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            beat_a[r] = accept ? in_a[r*DW +: DW] : '0;
            a_skew[r] = (r == 0) ? beat_a[r] : a_dly[r][(r > 0) ? r - 1 : 0];
        end
        for (int c = 0; c < COLS; c++) begin
            beat_b[c] = accept ? in_b[c*DW +: DW] : '0;
            b_skew[c] = (c == 0) ? beat_b[c] : b_dly[c][(c > 0) ? c - 1 : 0];
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            row_z[c*DW +: DW]    = acc[row_sel][c];
            row_relu[c*DW +: DW] = acc[row_sel][c][DW-1] ? '0 : acc[row_sel][c];
            row_d[c]             = !acc[row_sel][c][DW-1] && (|acc[row_sel][c][DW-2:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            flush_cnt <= FLUSH_LOAD;
            relu_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state != S_FLUSH) flush_cnt <= FLUSH_LOAD;
            else if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
            if (first_beat) relu_q <= cfg_relu;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_z     <= '0;
            out_d     <= '0;
        end else if (row_load) begin
            out_valid <= 1'b1;
            out_row   <= row_sel;
            out_z     <= relu_q ? row_relu : row_z;
            out_d     <= row_d;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    // Skew lines, operand pass-through registers and accumulators; bubbles carry zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < ROWS; j++) a_dly[r][j] <= '0;
            end
            for (int c = 0; c < COLS; c++) begin
                for (int j = 0; j < COLS; j++) b_dly[c][j] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_dly[r][0] <= beat_a[r];
                for (int j = 1; j < ROWS; j++) a_dly[r][j] <= a_dly[r][j-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_dly[c][0] <= beat_b[c];
                for (int j = 1; j < COLS; j++) b_dly[c][j] <= b_dly[c][j-1];
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= (c == 0) ? a_skew[r] : a_reg[r][(c > 0) ? c - 1 : 0];
                    b_reg[r][c] <= (r == 0) ? b_skew[c] : b_reg[(r > 0) ? r - 1 : 0][c];
                    if (acc_clr) acc[r][c] <= '0;
                    else if (acc_en) acc[r][c] <= fp_add(acc[r][c], fp_mul(a_reg[r][c], b_reg[r][c]));
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// Directed bench for systolic_gemm_ctrl (8x8): identity, gapped feed, back-pressure,
// accumulate, relu and mid-job reset, all against hand-computed fp32 values.
module tb_systolic_gemm_ctrl;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 32;
    localparam int RW   = 3;
    localparam logic [31:0]  F_ONE  = 32'h3F800000;
    localparam logic [31:0]  F_TWO  = 32'h40000000;
    localparam logic [31:0]  F_THR  = 32'h40400000;
    localparam logic [31:0]  F_FOUR = 32'h40800000;
    localparam logic [31:0]  F_NEG  = 32'hBFC00000;
    localparam logic [255:0] JUNK   = {8{32'hDEADBEEF}};

    logic               clk, reset, cfg_relu, cfg_accum;
    logic               in_valid, in_ready, in_last;
    logic [ROWS*DW-1:0] in_a;
    logic [COLS*DW-1:0] in_b;
    logic               out_valid, out_ready, out_last, busy;
    logic [RW-1:0]      out_row;
    logic [COLS*DW-1:0] out_z;
    logic [COLS-1:0]    out_d;

    systolic_gemm_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .cfg_relu(cfg_relu), .cfg_accum(cfg_accum),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .out_z(out_z), .out_d(out_d), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] ja [8];
    logic [255:0] jb [8];
    int           jk;
    logic [255:0] exp_z [8];
    logic [7:0]   exp_d [8];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic setup_identity();
        jk = 8;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < ROWS; r++) ja[k][r*32 +: 32] = (r == k) ? F_ONE : 32'd0;
            for (int c = 0; c < COLS; c++) jb[k][c*32 +: 32] = i2f(c + 8*k);
        end
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                exp_z[i][j*32 +: 32] = i2f(j + 8*i);
                exp_d[i][j] = ((j + 8*i) != 0);
            end
        end
    endtask

    task automatic setup_k3();
        jk = 3;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < ROWS; r++) ja[k][r*32 +: 32] = i2f(r + 1);
            for (int c = 0; c < COLS; c++) jb[k][c*32 +: 32] = i2f(k + c);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) exp_z[r][c*32 +: 32] = i2f((r + 1) * (3*c + 3));
            exp_d[r] = 8'hFF;
        end
    endtask

    task automatic setup_ones(input logic [31:0] z);
        jk = 2;
        for (int k = 0; k < 2; k++) begin
            ja[k] = {8{F_ONE}};
            jb[k] = {8{F_ONE}};
        end
        for (int r = 0; r < ROWS; r++) begin
            exp_z[r] = {8{z}};
            exp_d[r] = 8'hFF;
        end
    endtask

    task automatic setup_relu(input bit relu);
        jk = 1;
        ja[0] = {8{F_ONE}};
        jb[0] = {F_ONE, F_ONE, F_ONE, F_ONE, F_THR, F_TWO, 32'd0, F_NEG};
        for (int r = 0; r < ROWS; r++) begin
            exp_z[r] = relu ? {F_ONE, F_ONE, F_ONE, F_ONE, F_THR, F_TWO, 32'd0, 32'd0} : jb[0];
            exp_d[r] = 8'b1111_1100;
        end
    endtask

    task automatic feed(input int nb, input bit gaps, input bit relu, input bit accm);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            cfg_relu  = (k == 0) ? relu : !relu;
            cfg_accum = (k == 0) ? accm : !accm;
            in_valid = 1'b1; in_a = ja[k]; in_b = jb[k]; in_last = (k == jk - 1);
            check_val("in_ready_feed", in_ready, 1);
            @(posedge clk);
            if (gaps && k < nb - 1) begin
                @(negedge clk);
                in_valid = 1'b0; in_a = JUNK; in_b = JUNK;
            end
        end
        @(negedge clk);
        cfg_relu = !relu; cfg_accum = !accm;
        if (nb == jk) begin
            in_valid = 1'b1; in_a = JUNK; in_b = JUNK; in_last = 1'b1;
            check_val("in_ready_flush", in_ready, 0);
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        check_val("busy_job", busy, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", n, ROWS + COLS);
    endtask

    task automatic drain(input int hold_row, input int hold_n, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            check_val($sformatf("valid_r%0d", r), out_valid, 1);
            check_val($sformatf("row_r%0d", r), out_row, r);
            check_val($sformatf("last_r%0d", r), out_last, (r == ROWS - 1));
            check_val($sformatf("z_r%0d", r), out_z, exp_z[r]);
            check_val($sformatf("d_r%0d", r), out_d, exp_d[r]);
            if (r == hold_row) begin
                out_ready = 1'b0;
                repeat (hold_n) begin
                    @(negedge clk);
                    check_val("hold_valid", out_valid, 1);
                    check_val("hold_row", out_row, r);
                    check_val("hold_z", out_z, exp_z[r]);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        if (nrows == ROWS) begin
            check_val("valid_after", out_valid, 0);
            check_val("busy_after", busy, 0);
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_z", out_z, 0);
        check_val("rst_d", out_d, 0);
        check_val("rst_row", out_row, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_rel_in_ready", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; cfg_relu = 1'b0; cfg_accum = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("init_valid", out_valid, 0);
        check_val("init_in_ready", in_ready, 0);
        check_val("init_busy", busy, 0);
        check_val("init_z", out_z, 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("init_in_ready_rel", in_ready, 1);

        // identity A, then the same job with back-pressure on row 3
        setup_identity(); feed(8, 0, 0, 0); wait_valid(n); drain(-1, 0, ROWS);
        setup_identity(); feed(8, 0, 0, 0); wait_valid(n); drain(3, 5, ROWS);

        // K=3 back-to-back and with bubbles
        setup_k3(); feed(3, 0, 0, 0); wait_valid(n); drain(-1, 0, ROWS);
        setup_k3(); feed(3, 1, 0, 0); wait_valid(n); drain(-1, 0, ROWS);

        // accumulate: first job after reset accumulates onto zeros
        do_reset();
        setup_ones(F_TWO);  feed(2, 0, 0, 1); wait_valid(n); drain(-1, 0, ROWS);
        setup_ones(F_FOUR); feed(2, 0, 0, 1); wait_valid(n); drain(-1, 0, ROWS);
        setup_ones(F_TWO);  feed(2, 0, 0, 0); wait_valid(n); drain(-1, 0, ROWS);

        // relu on and off, K=1
        setup_relu(1); feed(1, 0, 1, 0); wait_valid(n); drain(-1, 0, ROWS);
        setup_relu(0); feed(1, 0, 0, 0); wait_valid(n); drain(-1, 0, ROWS);

        // reset mid-FEED, then a fresh job
        setup_identity(); feed(3, 0, 0, 0);
        do_reset();
        setup_ones(F_TWO); feed(2, 0, 0, 1); wait_valid(n); drain(-1, 0, ROWS);

        // reset mid-DRAIN, then a fresh job
        setup_identity(); feed(8, 0, 0, 0); wait_valid(n); drain(-1, 0, 3);
        do_reset();
        setup_identity(); feed(8, 0, 0, 0); wait_valid(n); drain(-1, 0, ROWS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
